// File: rtl/max16_sched_pkg.sv
// Shared definitions for the max16 round-robin scheduler: FSM encoding,
// default geometry and a constant-width helper.
package max16_sched_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_REQ_WIDTH = 128;
  localparam int DEF_RES_WIDTH = 8;
  localparam int DEF_LATENCY   = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  // Smallest r with 2**r >= value; used for localparam widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/max16_tag_pipe.sv
// Valid+tag delay line matching the datapath latency; only the valid bits
// are reset so a reset discards every in-flight result.
module max16_tag_pipe #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  // NOTE: tag storage has no reset; a tag is only ever read when its valid bit is set.
  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

endmodule

// File: rtl/max16_sched.sv
// Round-robin scheduler sharing one fixed-latency max16 datapath between
// NUM_REQ requesters, with result routing and a drain/idle handshake.
module max16_sched
  import max16_sched_pkg::*;
#(
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int REQ_WIDTH = DEF_REQ_WIDTH,
  parameter  int RES_WIDTH = DEF_RES_WIDTH,
  parameter  int LATENCY   = DEF_LATENCY,
  localparam int TAG_W     = clog2(NUM_REQ),
  localparam int CNT_W     = clog2(LATENCY + 2)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REQ_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         dp_valid,
  output logic [REQ_WIDTH-1:0]         dp_din,
  input  logic [RES_WIDTH-1:0]         dp_dout,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [RES_WIDTH-1:0]         rsp_data,
  input  logic                         drain,
  output logic                         idle,
  output logic [CNT_W-1:0]             inflight
);

  state_t           state, state_nxt;
  logic [TAG_W-1:0] rr_ptr, grant_idx, cand_idx, tag_reg, tp_tag;
  logic             grant_any, tp_valid;
  int               cand;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    req_ready = '0;
    if (state == ST_RUN && !drain) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        cand_idx = TAG_W'(cand);
        if (!grant_any && req_valid[cand_idx]) begin
          grant_any = 1'b1;
          grant_idx = cand_idx;
        end
      end
    end
    if (grant_any) req_ready[grant_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      dp_valid <= 1'b0;
      dp_din   <= '0;
      tag_reg  <= '0;
      inflight <= '0;
      state    <= ST_RUN;
    end else begin
      state    <= state_nxt;
      dp_valid <= grant_any;
      if (grant_any) begin
        dp_din  <= req_data[int'(grant_idx)*REQ_WIDTH +: REQ_WIDTH];
        tag_reg <= grant_idx;
        rr_ptr  <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end
      if (grant_any && !tp_valid)      inflight <= inflight + 1'b1;
      else if (!grant_any && tp_valid) inflight <= inflight - 1'b1;
    end
  end

  max16_tag_pipe #(
    .DEPTH (LATENCY),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (dp_valid),
    .in_tag    (tag_reg),
    .out_valid (tp_valid),
    .out_tag   (tp_tag)
  );

  always_comb begin
    rsp_valid = '0;
    if (tp_valid) rsp_valid[tp_tag] = 1'b1;
  end

  assign rsp_data = dp_dout;

  // DRAIN leaves as soon as the last retirement is under way, so IDLE follows
  // the final response directly; no grants are possible while draining.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (drain) state_nxt = ST_DRAIN;
      ST_DRAIN: if (inflight == CNT_W'(tp_valid)) state_nxt = ST_IDLE;
      ST_IDLE:  if (!drain) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  assign idle = (state == ST_IDLE);

endmodule

// File: tb/tb_max16_sched.sv
// Directed bench for max16_sched: arbitration order, issue/response timing,
// in-flight counting, drain/idle handshake and asynchronous reset.
module tb_max16_sched;

  localparam int NR  = 4;
  localparam int RW  = 128;
  localparam int RSW = 8;
  localparam int LAT = 16;
  localparam int CW  = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*RW-1:0] req_data  = '0;
  logic [NR-1:0]    req_ready;
  logic             dp_valid;
  logic [RW-1:0]    dp_din;
  logic [RSW-1:0]   dp_dout;
  logic [NR-1:0]    rsp_valid;
  logic [RSW-1:0]   rsp_data;
  logic             drain = 1'b0;
  logic             idle;
  logic [CW-1:0]    inflight;

  int checks = 0;
  int errors = 0;

  logic [7:0] max_tab    [4] = '{8'h80, 8'h91, 8'hA2, 8'hB3};
  logic [7:0] steady_tab [3] = '{8'hC3, 8'h9E, 8'hF0};

  always #5 clk = ~clk;

  max16_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dp_valid  (dp_valid),
    .dp_din    (dp_din),
    .dp_dout   (dp_dout),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .drain     (drain),
    .idle      (idle),
    .inflight  (inflight)
  );

  function automatic logic [7:0] max16(input logic [RW-1:0] v);
    logic [7:0] m;
    m = 8'h00;
    for (int j = 0; j < 16; j++) if (v[j*8 +: 8] > m) m = v[j*8 +: 8];
    return m;
  endfunction

  // Stand-in datapath: lane maximum, LAT cycles deep, never cleared.
  logic [7:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= max16(dp_din);
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_dout = dp_pipe[LAT-1];

  // Lanes other than pos stay at or below 0x3F, so the maximum is maxv.
  function automatic logic [RW-1:0] mk(input logic [7:0] maxv, input int pos, input logic [7:0] seed);
    logic [RW-1:0] r;
    for (int j = 0; j < 16; j++)
      r[j*8 +: 8] = (j == pos) ? maxv : ((seed + 8'(j * 5)) & 8'h3F);
    return r;
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    drain = 1'b0;
    advance();
    advance();
    rst = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) advance();
  endtask

  task automatic test_reset();
    advance();
    @(negedge clk);
    checks++; if (dp_valid !== 1'b0) begin errors++; $display("FAIL reset_dp_valid got %b exp 0", dp_valid); end
    checks++; if (inflight !== '0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL reset_idle got %b exp 0", idle); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    advance();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (dp_din !== '0) begin errors++; $display("FAIL reset_dp_din got %h exp 0", dp_din); end
    checks++; if (inflight !== '0 || idle !== 1'b0) begin errors++; $display("FAIL reset_release got inflight=%0d idle=%b exp 0/0", inflight, idle); end
    advance();
  endtask

  task automatic test_single();
    logic [RW-1:0] pay;
    do_reset();
    pay = mk(8'hA7, 5, 8'h11);
    req_data[0*RW +: RW] = mk(8'hFF, 0, 8'h01);
    req_data[1*RW +: RW] = mk(8'hFE, 1, 8'h02);
    req_data[2*RW +: RW] = pay;
    for (int c = 0; c <= 28; c++) begin
      req_valid = (c == 10) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      if (c == 10) begin
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready); end
      end
      if (c == 11) begin
        checks++; if (dp_valid !== 1'b1) begin errors++; $display("FAIL single_dp_valid got %b exp 1", dp_valid); end
        checks++; if (dp_din !== pay) begin errors++; $display("FAIL single_dp_din got %h exp %h", dp_din, pay); end
      end
      if (c == 12) begin
        checks++; if (dp_valid !== 1'b0) begin errors++; $display("FAIL single_dp_valid_low got %b exp 0", dp_valid); end
      end
      if (c >= 11 && c <= 27) begin
        checks++; if (inflight !== 5'd1) begin errors++; $display("FAIL single_inflight c=%0d got %0d exp 1", c, inflight); end
      end
      if (c == 28) begin
        checks++; if (inflight !== 5'd0) begin errors++; $display("FAIL single_inflight_done got %0d exp 0", inflight); end
      end
      if (c >= 11) begin
        checks++; if (rsp_valid !== ((c == 27) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_rsp_valid c=%0d got %b", c, rsp_valid); end
      end
      if (c == 27) begin
        checks++; if (rsp_data !== 8'hA7) begin errors++; $display("FAIL single_rsp_data got %h exp a7", rsp_data); end
      end
      advance();
    end
  endtask

  task automatic test_all_four();
    logic [NR-1:0] exp_ready, exp_rsp;
    logic [CW-1:0] exp_inf;
    do_reset();
    for (int i = 0; i < NR; i++) req_data[i*RW +: RW] = mk(max_tab[i], i + 3, 8'(i));
    req_valid = 4'b1111;
    for (int c = 0; c <= 40; c++) begin
      exp_ready = 4'b0001 << (c % 4);
      exp_rsp   = (c >= 17) ? (4'b0001 << ((c - 17) % 4)) : 4'b0000;
      exp_inf   = (c < 17) ? CW'(c) : 5'd17;
      @(negedge clk);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL all4_ready c=%0d got %b exp %b", c, req_ready, exp_ready); end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL all4_rsp_valid c=%0d got %b exp %b", c, rsp_valid, exp_rsp); end
      checks++; if (inflight !== exp_inf) begin errors++; $display("FAIL all4_inflight c=%0d got %0d exp %0d", c, inflight, exp_inf); end
      if (c >= 17) begin
        checks++; if (rsp_data !== max_tab[(c - 17) % 4]) begin errors++; $display("FAIL all4_rsp_data c=%0d got %h exp %h", c, rsp_data, max_tab[(c - 17) % 4]); end
      end
      advance();
    end
    req_valid = '0;
    wait_cycles(20);
  endtask

  task automatic test_pattern_1010();
    logic [NR-1:0] exp_ready;
    do_reset();
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      exp_ready = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      @(negedge clk);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr1010 c=%0d got %b exp %b", c, req_ready, exp_ready); end
      advance();
    end
    req_valid = '0;
    wait_cycles(20);
  endtask

  task automatic test_drain();
    logic [NR-1:0] exp_ready, exp_rsp;
    logic          exp_idle;
    int            exp_inf;
    do_reset();
    for (int i = 0; i < NR; i++) req_data[i*RW +: RW] = mk(max_tab[i], 15 - i, 8'(i + 7));
    for (int c = 0; c <= 25; c++) begin
      req_valid = (c <= 24) ? 4'b1111 : 4'b0000;
      drain     = (c >= 5 && c <= 22);
      exp_ready = (c < 5) ? (4'b0001 << (c % 4)) : (c == 24) ? 4'b0010 : 4'b0000;
      exp_rsp   = (c >= 17 && c <= 21) ? (4'b0001 << ((c - 17) % 4)) : 4'b0000;
      exp_idle  = (c == 22 || c == 23);
      exp_inf   = (c <= 5) ? c : (c <= 17) ? 5 : (c <= 22) ? 22 - c : (c <= 24) ? 0 : 1;
      @(negedge clk);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL drain_ready c=%0d got %b exp %b", c, req_ready, exp_ready); end
      checks++; if (idle !== exp_idle) begin errors++; $display("FAIL drain_idle c=%0d got %b exp %b", c, idle, exp_idle); end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL drain_rsp_valid c=%0d got %b exp %b", c, rsp_valid, exp_rsp); end
      checks++; if (inflight !== CW'(exp_inf)) begin errors++; $display("FAIL drain_inflight c=%0d got %0d exp %0d", c, inflight, exp_inf); end
      if (c >= 17 && c <= 21) begin
        checks++; if (rsp_data !== max_tab[(c - 17) % 4]) begin errors++; $display("FAIL drain_rsp_data c=%0d got %h exp %h", c, rsp_data, max_tab[(c - 17) % 4]); end
      end
      advance();
    end
    req_valid = '0;
    drain = 1'b0;
    wait_cycles(20);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      req_valid = (c <= 5) ? 4'b1111 : 4'b0000;
      if (c < 8) advance();
    end
    @(negedge clk);
    checks++; if (inflight !== 5'd6) begin errors++; $display("FAIL arst_before got %0d exp 6", inflight); end
    advance();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (inflight !== '0) begin errors++; $display("FAIL arst_inflight got %0d exp 0", inflight); end
    checks++; if (dp_valid !== 1'b0) begin errors++; $display("FAIL arst_dp_valid got %b exp 0", dp_valid); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL arst_rsp_valid got %b exp 0000", rsp_valid); end
    advance();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL arst_discard c=%0d got %b exp 0000", c, rsp_valid); end
      advance();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL arst_ptr got %b exp 0001", req_ready); end
    advance();
    req_valid = '0;
    wait_cycles(20);
  endtask

  task automatic test_steady();
    logic [NR-1:0] exp_ready, exp_rsp;
    logic [CW-1:0] exp_inf;
    logic          g;
    do_reset();
    for (int c = 0; c <= 52; c++) begin
      g = (c % 17 == 0) && (c <= 34);
      if (g) req_data[3*RW +: RW] = mk(steady_tab[c / 17], c % 16, 8'(c));
      req_valid = g ? 4'b1000 : 4'b0000;
      exp_ready = g ? 4'b1000 : 4'b0000;
      exp_rsp   = (c >= 17 && c % 17 == 0) ? 4'b1000 : 4'b0000;
      exp_inf   = (c >= 1 && c <= 51) ? 5'd1 : 5'd0;
      @(negedge clk);
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL steady_ready c=%0d got %b exp %b", c, req_ready, exp_ready); end
      checks++; if (inflight !== exp_inf) begin errors++; $display("FAIL steady_inflight c=%0d got %0d exp %0d", c, inflight, exp_inf); end
      checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL steady_rsp_valid c=%0d got %b exp %b", c, rsp_valid, exp_rsp); end
      if (exp_rsp != 4'b0000) begin
        checks++; if (rsp_data !== steady_tab[c / 17 - 1]) begin errors++; $display("FAIL steady_rsp_data c=%0d got %h exp %h", c, rsp_data, steady_tab[c / 17 - 1]); end
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_pattern_1010();
    test_drain();
    test_async_reset();
    test_steady();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
